// File: rtl/snake_body_engine.sv
// snake_body_engine: circular-buffer snake body, move/collision sequencer and cell plotter; SNAKE_WRAP_EN makes walls wrap
module snake_body_engine #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int CELL = 4,
  parameter int X_MAX = 156,
  parameter int Y_MAX = 116,
  parameter int MAX_LEN = 64,
  parameter int INIT_LEN = 4,
  parameter int INIT_X = 60,
  parameter int INIT_Y = 60,
  parameter logic [2:0] BODY_C = 3'b010,
  parameter logic [2:0] ERASE_C = 3'b000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic                       step_req,
  input  logic                       grow,
  input  logic [1:0]                 dir,
  output logic                       ready,
  output logic                       done,
  output logic                       dead,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic [X_W-1:0]             head_x,
  output logic [Y_W-1:0]             head_y,
  output logic                       plot,
  output logic [X_W-1:0]             x,
  output logic [Y_W-1:0]             y,
  output logic [2:0]                 colour
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CELL);
  localparam int QW = 2 * CW;
  localparam logic [X_W:0] XC = (X_W+1)'(CELL);
  localparam logic [X_W:0] XM = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0] YC = (Y_W+1)'(CELL);
  localparam logic [Y_W:0] YM = (Y_W+1)'(Y_MAX);
  typedef enum logic [3:0] {IDLE, INIT, MOVE, SCAN, COMMIT, ERASE, DRAW, DONE, DEAD} state_t;
  state_t st, nst;
  logic [PW-1:0] hp, tp;
  logic [LW-1:0] cnt;
  logic [QW-1:0] pc;
  logic [1:0] last_dir, dir_q, dir_eff;
  logic grow_q, eff_grow, at_tail, hit, wall, wall_x, wall_y;
  logic [X_W-1:0] cx, tail_x, px, mx, x_q;
  logic [Y_W-1:0] cy, tail_y, py, my, y_q, init_y;
  logic [2:0] c_q;
  logic [X_W:0] nx;
  logic [Y_W:0] ny;
  logic [X_W+Y_W-1:0] mem [MAX_LEN];
  logic [X_W+Y_W-1:0] rd_data, wdata;
  logic [PW-1:0] waddr, raddr;
  logic we;
  always_comb begin
    dir_eff = (dir == {last_dir[1], ~last_dir[0]}) ? last_dir : dir;
    nx = dir_q == 2'b00 ? {1'b0, head_x} + XC : dir_q == 2'b01 ? {1'b0, head_x} - XC : {1'b0, head_x};
    ny = dir_q == 2'b10 ? {1'b0, head_y} + YC : dir_q == 2'b11 ? {1'b0, head_y} - YC : {1'b0, head_y};
    // negative results show up as huge unsigned values, so one compare covers both walls
    wall_x = nx > XM;
    wall_y = ny > YM;
`ifdef SNAKE_WRAP_EN
    mx = !wall_x ? nx[X_W-1:0] : nx[X_W] ? XM[X_W-1:0] : '0;
    my = !wall_y ? ny[Y_W-1:0] : ny[Y_W] ? YM[Y_W-1:0] : '0;
    wall = 1'b0;
`else
    mx = nx[X_W-1:0];
    my = ny[Y_W-1:0];
    wall = wall_x | wall_y;
`endif
    eff_grow = grow_q && (length < LW'(MAX_LEN));
    at_tail = (hp + cnt[PW-1:0] - PW'(1)) == tp;
    hit = (cnt != '0) && (rd_data == {cx, cy}) && (!at_tail || eff_grow);
    init_y = Y_W'(INIT_Y + int'(cnt) * CELL);
    we = (st == INIT) || (st == COMMIT);
    waddr = st == INIT ? cnt[PW-1:0] : hp - PW'(1);
    wdata = st == INIT ? {X_W'(INIT_X), init_y} : {cx, cy};
    raddr = hp + cnt[PW-1:0];
    ready = st == IDLE;
    done = (st == DONE) || (st == DEAD);
    plot = (st == ERASE) || (st == DRAW);
    px = (st == ERASE ? tail_x : head_x) + X_W'(pc[CW-1:0]);
    py = (st == ERASE ? tail_y : head_y) + Y_W'(pc[QW-1:CW]);
    x = plot ? px : x_q;
    y = plot ? py : y_q;
    colour = plot ? (st == ERASE ? ERASE_C : BODY_C) : c_q;
  end
  always_comb begin
    nst = st;
    case (st)
      IDLE: nst = init ? INIT : (step_req && !dead) ? MOVE : IDLE;
      INIT: nst = (cnt == LW'(INIT_LEN - 1)) ? DONE : INIT;
      MOVE: nst = wall ? DEAD : SCAN;
      SCAN: nst = hit ? DEAD : (cnt == length) ? COMMIT : SCAN;
      COMMIT: nst = eff_grow ? DRAW : ERASE;
      ERASE: nst = &pc ? DRAW : ERASE;
      DRAW: nst = &pc ? DONE : DRAW;
      default: nst = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[raddr];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      hp <= '0;
      tp <= '0;
      cnt <= '0;
      pc <= '0;
      length <= '0;
      head_x <= X_W'(INIT_X);
      head_y <= Y_W'(INIT_Y);
      last_dir <= 2'b11;
      dir_q <= 2'b11;
      grow_q <= 1'b0;
      cx <= '0;
      cy <= '0;
      tail_x <= '0;
      tail_y <= '0;
      dead <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      c_q <= '0;
    end else begin
      st <= nst;
      x_q <= x;
      y_q <= y;
      c_q <= colour;
      case (st)
        IDLE: begin
          if (init) begin
            hp <= '0;
            tp <= PW'(INIT_LEN - 1);
            cnt <= '0;
            length <= LW'(INIT_LEN);
            head_x <= X_W'(INIT_X);
            head_y <= Y_W'(INIT_Y);
            last_dir <= 2'b11;
            dead <= 1'b0;
          end else if (step_req && !dead) begin
            dir_q <= dir_eff;
            grow_q <= grow;
          end
        end
        INIT: cnt <= cnt + LW'(1);
        MOVE: begin
          cx <= mx;
          cy <= my;
          cnt <= '0;
        end
        SCAN: begin
          cnt <= cnt + LW'(1);
          if (cnt != '0 && at_tail) {tail_x, tail_y} <= rd_data;
        end
        COMMIT: begin
          hp <= hp - PW'(1);
          head_x <= cx;
          head_y <= cy;
          last_dir <= dir_q;
          pc <= '0;
          if (eff_grow) length <= length + LW'(1);
          else tp <= tp - PW'(1);
        end
        ERASE, DRAW: pc <= pc + QW'(1);
        default: ;
      endcase
      if (nst == DEAD) dead <= 1'b1;
    end
  end
endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: directed and random moves checked against a queue-based snake model
module tb_snake_body_engine;
  localparam int ML = 8;
  logic clk = 0, rst = 0, init = 0, step_req = 0, grow = 0;
  logic [1:0] dir = 0;
  logic ready, done, dead, plot;
  logic [3:0] length;
  logic [7:0] head_x, x;
  logic [6:0] head_y, y;
  logic [2:0] colour;
  int checks = 0, errors = 0;
  typedef struct {int x; int y;} cell_t;
  cell_t body[$];
  int m_dir = 3, m_dead = 0, hx = 60, hy = 60;
  int exp_pix[$], obs_pix[$];
  always #5 clk = ~clk;
  snake_body_engine #(.MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .init(init), .step_req(step_req), .grow(grow), .dir(dir),
    .ready(ready), .done(done), .dead(dead), .length(length), .head_x(head_x), .head_y(head_y),
    .plot(plot), .x(x), .y(y), .colour(colour)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run(output int n);
    n = 0;
    obs_pix = {};
    while (1) begin
      @(posedge clk);
      #1;
      init = 0;
      step_req = 0;
      n++;
      if (plot) obs_pix.push_back(int'({x, y, colour}));
      if (done || n >= 400) break;
    end
    chk("done_seen", done, 1);
  endtask
  task automatic add_raster(input int cx, input int cy, input int c);
    for (int i = 0; i < 16; i++) exp_pix.push_back(((cx + i % 4) << 10) | ((cy + i / 4) << 3) | c);
  endtask
  task automatic cmp_pix();
    int e0;
    chk("pixel_count", obs_pix.size(), exp_pix.size());
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
      e0 = errors;
      chk("pixel", obs_pix[i], exp_pix[i]);
      if (errors != e0) break;
    end
  endtask
  task automatic check_state();
    chk("length", length, body.size());
    chk("head_x", head_x, hx);
    chk("head_y", head_y, hy);
    chk("dead", dead, m_dead);
    chk("plot_at_done", plot, 0);
    @(posedge clk);
    #1;
    chk("ready_after", ready, 1);
    chk("done_one_cycle", done, 0);
  endtask
  task automatic do_init();
    int n;
    init = 1;
    run(n);
    body = {};
    for (int k = 0; k < 4; k++) body.push_back('{60, 60 + 4 * k});
    m_dir = 3;
    m_dead = 0;
    hx = 60;
    hy = 60;
    chk("init_latency", n, 5);
    chk("init_plots", obs_pix.size(), 0);
    check_state();
  endtask
  task automatic do_step(input int d, input int g);
    int ed, nx, ny, n, L, seen;
    bit wall, hit, eg;
    dir = 2'(d);
    grow = g[0];
    step_req = 1;
    if (m_dead) begin
      seen = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        step_req = 0;
        if (done || !ready) seen = 1;
      end
      chk("step_ignored", seen, 0);
      chk("dead_hold", dead, 1);
      chk("ignored_head_y", head_y, hy);
      return;
    end
    ed = (d == (m_dir ^ 1)) ? m_dir : d;
    nx = hx + (ed == 0 ? 4 : ed == 1 ? -4 : 0);
    ny = hy + (ed == 2 ? 4 : ed == 3 ? -4 : 0);
`ifdef SNAKE_WRAP_EN
    if (nx < 0) nx = 156; else if (nx > 156) nx = 0;
    if (ny < 0) ny = 116; else if (ny > 116) ny = 0;
    wall = 0;
`else
    wall = nx < 0 || nx > 156 || ny < 0 || ny > 116;
`endif
    L = body.size();
    eg = g != 0 && L < ML;
    hit = 0;
    for (int i = 0; i < L; i++)
      if ((i < L - 1 || eg) && body[i].x == nx && body[i].y == ny) hit = 1;
    exp_pix = {};
    if (wall || hit) m_dead = 1;
    else begin
      if (!eg) begin
        add_raster(body[L-1].x, body[L-1].y, 0);
        void'(body.pop_back());
      end
      add_raster(nx, ny, 2);
      body.push_front('{nx, ny});
      hx = nx;
      hy = ny;
      m_dir = ed;
    end
    run(n);
    if (wall) chk("wall_latency", n, 2);
    else if (!hit) chk("step_latency", n, L + (eg ? 20 : 36));
    cmp_pix();
    check_state();
  endtask
  initial begin
    #7;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_dead", dead, 0);
    chk("rst_plot", plot, 0);
    chk("rst_length", length, 0);
    chk("rst_head_x", head_x, 60);
    chk("rst_head_y", head_y, 60);
    chk("rst_xyc", {x, y, colour}, 0);
    @(posedge clk);
    #1;
    rst = 1;
    do_init();
    do_step(0, 0);
    chk("t2_head_x", head_x, 64);
    chk("t2_first_erase", obs_pix.size() > 0 ? obs_pix[0] : -1, (60 << 10) | (72 << 3));
    chk("t2_first_draw", obs_pix.size() > 16 ? obs_pix[16] : -1, (64 << 10) | (60 << 3) | 2);
    do_init();
    do_step(2, 0);
    chk("t3_head_y", head_y, 56);
    chk("t3_dead", dead, 0);
    do_init();
    repeat (15) do_step(3, 0);
    chk("t4_y0", head_y, 0);
    do_step(3, 0);
`ifdef SNAKE_WRAP_EN
    chk("t4_wrap_y", head_y, 116);
    chk("t4_dead", dead, 0);
`else
    chk("t4_dead", dead, 1);
    chk("t4_head_kept", head_y, 0);
`endif
    do_step(0, 0);
    do_init();
    chk("t4_init_clears", dead, 0);
    do_init();
    repeat (5) do_step(0, 1);
    chk("t5_length_sat", length, 8);
    do_step(2, 0);
    do_step(1, 0);
    do_step(1, 0);
    do_step(2, 1);
    do_step(0, 0);
    do_init();
    do_step(0, 1);
    do_step(0, 0);
    do_step(2, 0);
    do_step(1, 0);
    do_step(3, 0);
    chk("t6_self_hit", dead, 1);
    do_init();
    do_step(0, 0);
    do_step(2, 0);
    do_step(1, 0);
    do_step(3, 0);
    chk("t6_tail_vacates", dead, 0);
    repeat (60) begin
      if (m_dead && $urandom_range(0, 2) == 0) do_init();
      else do_step(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end
    if (m_dead) do_init();
    dir = 0;
    grow = 0;
    step_req = 1;
    @(posedge clk);
    #1;
    step_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_plot", plot, 0);
    chk("midrst_length", length, 0);
    chk("midrst_head_x", head_x, 60);
    @(posedge clk);
    #1;
    rst = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
